// File: rtl/psum_collector_pkg.sv
// psum_collector_pkg
//   Shared definitions for the partial-sum collector below the systolic array.
//   - ACC_DW_DEFAULT : default width of one signed column psum
//   - COLS_DEFAULT   : default number of PE columns
//   - slice_lsb()    : bit offset of column c inside a packed row
//   - stall_headroom(): entries kept free for skewed data still in flight
//   - fifo_op_e      : per-cycle FIFO operation (push/pop combination)
package psum_collector_pkg;

    localparam int unsigned ACC_DW_DEFAULT = 32;
    localparam int unsigned COLS_DEFAULT   = 4;

    // One FIFO slot per column may still be in flight when STALL rises,
    // because columns are skewed by one cycle each.
    localparam int unsigned STALL_HEADROOM = COLS_DEFAULT;

    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_POP  = 2'b01,
        FIFO_PUSH = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

    // Column c occupies bits [c*w +: w] of a packed row.
    function automatic int unsigned slice_lsb(input int unsigned c, input int unsigned w);
        return c * w;
    endfunction

    // Headroom scales with the column count when COLS is overridden.
    function automatic int unsigned stall_headroom(input int unsigned cols);
        return cols;
    endfunction

endpackage

// File: rtl/psum_column_fifo.sv
// psum_column_fifo
//   Synchronous FIFO holding the psums of one PE column.
//   Ports:
//     clk   : clock, rising edge
//     rst   : asynchronous clear of pointers/count, active-high
//     clr   : synchronous clear of pointers/count, active-high
//     push  : write request; ignored when full unless a pop happens too
//     pop   : read request; ignored when empty
//     din   : write data
//     full  : count == DEPTH
//     empty : count == 0
//     count : occupancy, 0..DEPTH
//     head  : oldest entry (undefined when empty)
module psum_column_fifo
    import psum_collector_pkg::*;
#(
    parameter  int unsigned W     = ACC_DW_DEFAULT,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic [W-1:0]  head
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;
    fifo_op_e      op;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // A full FIFO still accepts a write when it pops on the same edge:
    // the freed slot is reused, so occupancy stays at DEPTH.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign op      = fifo_op_e'({do_push, do_pop});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case (op)
                FIFO_PUSH: count <= count + CW'(1);
                FIFO_POP:  count <= count - CW'(1);
                default:   count <= count;
            endcase
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/psum_collector.sv
// psum_collector
//   Collects skewed column psums from the bottom PE row into per-column
//   FIFOs and emits complete rows over a valid/ready handshake.
//   Ports:
//     CLK       : clock, rising edge
//     ASYNC_RST : asynchronous reset, active-high
//     SYNC_RST  : synchronous clear, active-high (same effect as ASYNC_RST)
//     PsumIn    : column psums, column c at [c*W +: W]
//     ColValid  : per-column write strobes
//     OutData   : assembled row (zero when OutValid=0)
//     OutValid  : every column FIFO holds at least one entry
//     OutReady  : downstream accepts the row
//     STALL     : registered backpressure to the array controller
//     OVERFLOW  : sticky, a write hit a full FIFO
//     RowCount  : rows accepted downstream, wrapping
//   DEPTH must be a power of two and at least 2*COLS.
module psum_collector
    import psum_collector_pkg::*;
#(
    parameter  int unsigned COLS                   = COLS_DEFAULT,
    parameter  int unsigned ACCUMULATOR_DATA_WIDTH = ACC_DW_DEFAULT,
    parameter  int unsigned DEPTH                  = 8,
    parameter  int unsigned CNT_WIDTH              = 16,
    localparam int unsigned W                      = ACCUMULATOR_DATA_WIDTH,
    localparam int unsigned CW                     = $clog2(DEPTH + 1)
) (
    input  logic                 CLK,
    input  logic                 ASYNC_RST,
    input  logic                 SYNC_RST,
    input  logic [COLS*W-1:0]    PsumIn,
    input  logic [COLS-1:0]      ColValid,
    output logic [COLS*W-1:0]    OutData,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic                 STALL,
    output logic                 OVERFLOW,
    output logic [CNT_WIDTH-1:0] RowCount
);

    localparam logic [CW-1:0] STALL_THRESH = CW'(DEPTH - stall_headroom(COLS));

    logic [COLS-1:0] full_vec;
    logic [COLS-1:0] empty_vec;
    logic [CW-1:0]   count_arr [COLS];
    logic [W-1:0]    head_arr  [COLS];
    logic [CW-1:0]   cnt_nxt   [COLS];
    logic [COLS-1:0] acc_vec;
    logic            pop;
    logic            stall_d;
    logic            ovf_hit;

    for (genvar c = 0; c < COLS; c++) begin : g_col
        psum_column_fifo #(
            .W     (W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (CLK),
            .rst   (ASYNC_RST),
            .clr   (SYNC_RST),
            .push  (ColValid[c]),
            .pop   (pop),
            .din   (PsumIn[slice_lsb(c, W) +: W]),
            .full  (full_vec[c]),
            .empty (empty_vec[c]),
            .count (count_arr[c]),
            .head  (head_arr[c])
        );
    end

    assign OutValid = &(~empty_vec);
    assign pop      = OutValid && OutReady;

    // Mirror each FIFO's accept rule to get its post-edge occupancy, so
    // STALL reflects the counts the FIFOs will hold after this edge.
    always_comb begin
        acc_vec = '0;
        stall_d = 1'b0;
        for (int unsigned c = 0; c < COLS; c++) begin
            acc_vec[c] = ColValid[c] && (!full_vec[c] || pop);
            cnt_nxt[c] = count_arr[c] + CW'(acc_vec[c]) - CW'(pop);
            if (cnt_nxt[c] >= STALL_THRESH) stall_d = 1'b1;
        end
    end

    // A full FIFO that pops on the same edge takes the write, so it is
    // not an overflow.
    assign ovf_hit = |(ColValid & full_vec & ~{COLS{pop}});

    always_comb begin
        OutData = '0;
        if (OutValid) begin
            for (int unsigned c = 0; c < COLS; c++) begin
                OutData[slice_lsb(c, W) +: W] = head_arr[c];
            end
        end
    end

    always_ff @(posedge CLK or posedge ASYNC_RST) begin
        if (ASYNC_RST) begin
            STALL    <= 1'b0;
            OVERFLOW <= 1'b0;
            RowCount <= '0;
        end else if (SYNC_RST) begin
            STALL    <= 1'b0;
            OVERFLOW <= 1'b0;
            RowCount <= '0;
        end else begin
            STALL <= stall_d;
            if (ovf_hit) OVERFLOW <= 1'b1;
            if (pop)     RowCount <= RowCount + CNT_WIDTH'(1);
        end
    end

endmodule
